// File: rtl/sort_ctrl.sv
// sort_ctrl: loads DEPTH words, bubble-sorts them in place with one compare-and-swap per cycle, then streams them out ascending (optional SORT_SWAP_CNT_EN adds swap_count).
// Latency: DEPTH-1 sort cycles when the block is already ordered, (DEPTH-1)^2 in the worst case; all outputs come from registers or from the state decode.
// Backpressure: in_ready is high only in LOAD; out_data holds while out_ready is low; flush aborts to LOAD from any state.

module sort_cmp #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq,
    output logic         a_gt,
    output logic         b_gt
);
    assign eq   = (a == b);
    assign a_gt = (a > b);
    assign b_gt = (a < b);
endmodule

module sort_ctrl #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int IW    = $clog2(DEPTH),
    localparam int SCW   = $clog2(DEPTH * (DEPTH - 1) / 2 + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             sort_done
`ifdef SORT_SWAP_CNT_EN
    ,
    output logic [SCW-1:0]   swap_count
`endif
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_J   = IW'(DEPTH - 2);

    state_t            state_q, state_d;
    logic [IW-1:0]     wr_idx_q, wr_idx_d;
    logic [IW-1:0]     rd_idx_q, rd_idx_d;
    logic [IW-1:0]     j_q, j_d;
    logic [IW-1:0]     pass_q, pass_d;
    logic              swapped_q, swapped_d;
    logic              in_ready_q, in_ready_d;
    logic              sort_done_q, sort_done_d;
    logic [SCW-1:0]    swap_cnt_q, swap_cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    logic [IW-1:0]     j_nxt;
    logic [WIDTH-1:0]  cmp_a, cmp_b;
    logic              cmp_eq, cmp_a_gt, cmp_b_gt;
    logic              do_swap;
    logic              pass_swapped;

    assign j_nxt = j_q + IW'(1);
    assign cmp_a = mem_q[j_q];
    assign cmp_b = mem_q[j_nxt];

    sort_cmp #(.N(WIDTH)) u_cmp (
        .a    (cmp_a),
        .b    (cmp_b),
        .eq   (cmp_eq),
        .a_gt (cmp_a_gt),
        .b_gt (cmp_b_gt)
    );

    // Equal words never swap, which keeps the sort stable.
    assign do_swap = cmp_a_gt && !(cmp_eq || cmp_b_gt);

    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        j_d          = j_q;
        pass_d       = pass_q;
        swapped_d    = swapped_q;
        swap_cnt_d   = swap_cnt_q;
        mem_d        = mem_q;
        pass_swapped = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    mem_d[wr_idx_q] = in_data;
                    if (wr_idx_q == LAST_IDX) begin
                        state_d    = ST_SORT;
                        wr_idx_d   = '0;
                        j_d        = '0;
                        pass_d     = '0;
                        swapped_d  = 1'b0;
                        swap_cnt_d = '0;
                    end else begin
                        wr_idx_d = wr_idx_q + IW'(1);
                    end
                end
            end
            ST_SORT: begin
                if (do_swap) begin
                    mem_d[j_q]   = cmp_b;
                    mem_d[j_nxt] = cmp_a;
                    swapped_d    = 1'b1;
                    swap_cnt_d   = swap_cnt_q + SCW'(1);
                end
                if (j_q == LAST_J) begin
                    pass_swapped = swapped_q || do_swap;
                    // A clean pass means ordered; DEPTH-1 passes always suffice.
                    if (!pass_swapped || pass_q == LAST_J) begin
                        state_d  = ST_OUT;
                        rd_idx_d = '0;
                    end else begin
                        j_d       = '0;
                        pass_d    = pass_q + IW'(1);
                        swapped_d = 1'b0;
                    end
                end else begin
                    j_d = j_nxt;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        state_d  = ST_LOAD;
                        rd_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Abort wins over any handshake or swap in the same cycle.
        if (flush) begin
            state_d    = ST_LOAD;
            wr_idx_d   = '0;
            rd_idx_d   = '0;
            j_d        = '0;
            pass_d     = '0;
            swapped_d  = 1'b0;
            swap_cnt_d = '0;
            mem_d      = mem_q;
        end

        in_ready_d  = (state_d == ST_LOAD);
        sort_done_d = (state_q == ST_SORT) && (state_d == ST_OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            j_q         <= '0;
            pass_q      <= '0;
            swapped_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            sort_done_q <= 1'b0;
            swap_cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            j_q         <= j_d;
            pass_q      <= pass_d;
            swapped_q   <= swapped_d;
            in_ready_q  <= in_ready_d;
            sort_done_q <= sort_done_d;
            swap_cnt_q  <= swap_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q == ST_SORT);
    assign sort_done = sort_done_q;
    assign out_data  = (state_q == ST_OUT) ? mem_q[rd_idx_q] : '0;

`ifdef SORT_SWAP_CNT_EN
    assign swap_count = swap_cnt_q;
`else
    logic unused_swap_cnt;
    assign unused_swap_cnt = ^swap_cnt_q;
`endif

endmodule

// File: tb/tb_sort_ctrl.sv
// Directed bench for sort_ctrl (WIDTH=4, DEPTH=8): table of blocks with hand-sorted results,
// plus hand-written sequences for out_ready stalls, flush mid-sort and async reset mid-output.

module tb_sort_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       sort_done;
`ifdef SORT_SWAP_CNT_EN
    logic [4:0] swap_count;
`endif

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic [31:0] din;
        logic [31:0] exp;
        logic [7:0]  busy_cyc;
        logic [7:0]  swaps;
    } vec_t;

    vec_t vecs [4];

    sort_ctrl #(.WIDTH(4), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .sort_done (sort_done)
`ifdef SORT_SWAP_CNT_EN
        ,
        .swap_count(swap_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge after the last word is accepted.
    task automatic load_words(input logic [31:0] din);
        int t;
        for (int k = 0; k < 8; k++) begin
            t = 0;
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                check("load_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            in_valid = 1'b1;
            in_data  = din[4*k +: 4];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input int v);
        int busy_n, done_n, got, cyc, first_ov, last_ov, done_cyc;
        logic [31:0] expw;
        expw      = vecs[v].exp;
        out_ready = 1'b1;
        load_words(vecs[v].din);
        busy_n = 0; done_n = 0; got = 0; cyc = 0;
        first_ov = -1; last_ov = -1; done_cyc = -2;
        while (1) begin
            if (busy) busy_n++;
            if (sort_done) begin
                done_n++;
                done_cyc = cyc;
`ifdef SORT_SWAP_CNT_EN
                check($sformatf("v%0d swap_count", v), int'(swap_count), int'(vecs[v].swaps));
`endif
            end
            if (out_valid && got < 8) begin
                if (first_ov < 0) first_ov = cyc;
                last_ov = cyc;
                check($sformatf("v%0d word%0d", v, got), int'(out_data), int'(expw[4*got +: 4]));
                got++;
            end
            if (got == 8 || cyc >= 300) break;
            @(negedge clk);
            cyc++;
        end
        if (got < 8) check($sformatf("v%0d out_timeout", v), got, 8);
        check($sformatf("v%0d busy_cycles", v), busy_n, int'(vecs[v].busy_cyc));
        check($sformatf("v%0d sort_done_count", v), done_n, 1);
        check($sformatf("v%0d sort_done_at_first_out", v), done_cyc, first_ov);
        check($sformatf("v%0d out_valid_run", v), last_ov - first_ov + 1, 8);
        @(negedge clk);
        check($sformatf("v%0d in_ready_after", v), int'(in_ready), 1);
        check($sformatf("v%0d out_valid_after", v), int'(out_valid), 0);
    endtask

    initial begin
        int t, c, got, bad_d, bad_ir, n, sd;

        vecs[0] = '{din: 32'h62951413, exp: 32'h96543211, busy_cyc: 8'd35, swaps: 8'd8};
        vecs[1] = '{din: 32'h76543210, exp: 32'h76543210, busy_cyc: 8'd7,  swaps: 8'd0};
        vecs[2] = '{din: 32'h89ABCDEF, exp: 32'hFEDCBA98, busy_cyc: 8'd49, swaps: 8'd28};
        vecs[3] = '{din: 32'h00000001, exp: 32'h10000000, busy_cyc: 8'd14, swaps: 8'd7};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        check("rst in_ready", int'(in_ready), 0);
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_data", int'(out_data), 0);
        check("rst busy", int'(busy), 0);
        check("rst sort_done", int'(sort_done), 0);
        @(negedge clk);
        @(negedge clk);
        check("rst held in_ready", int'(in_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("first in_ready", int'(in_ready), 1);

        for (int v = 0; v < 4; v++) run_vec(v);

        // All-equal block drained under a 1,0,0 out_ready pattern.
        out_ready = 1'b0;
        load_words(32'h77777777);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("sevens reach out", int'(out_valid), 1);
        c = 0; got = 0; bad_d = 0; bad_ir = 0;
        while (got < 8 && c < 60) begin
            out_ready = (c % 3 == 0);
            if (!out_valid || out_data != 4'd7) bad_d++;
            if (in_ready) bad_ir++;
            if (out_ready) got++;
            @(negedge clk);
            c++;
        end
        check("sevens emitted", got, 8);
        check("sevens out cycles", c, 22);
        check("sevens bad data", bad_d, 0);
        check("sevens early in_ready", bad_ir, 0);
        check("sevens in_ready after", int'(in_ready), 1);
        out_ready = 1'b0;

        // Flush on the 10th sort cycle with a word offered at the same time.
        load_words(vecs[2].din);
        n = 1;
        while (n < 10 && busy) begin
            @(negedge clk);
            n++;
        end
        check("flush reached sort cycle 10", int'(busy), 1);
        flush = 1'b1; in_valid = 1'b1; in_data = 4'd5;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush busy", int'(busy), 0);
        check("flush in_ready", int'(in_ready), 1);
        check("flush out_valid", int'(out_valid), 0);
        sd = 0;
        for (int k = 0; k < 5; k++) begin
            if (sort_done || busy) sd++;
            @(negedge clk);
        end
        check("flush no sort_done", sd, 0);
        run_vec(0);

        // Stalled output, stepping, then async reset between edges.
        out_ready = 1'b0;
        load_words(vecs[0].din);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("hold word0", int'(out_data), 1);
        @(negedge clk);
        check("hold word0 again", int'(out_data), 1);
        check("hold out_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("step word1", int'(out_data), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("step word2", int'(out_data), 2);
        @(negedge clk);
        check("hold word2", int'(out_data), 2);
        #2 rst = 1'b1;
        #1;
        check("arst out_valid", int'(out_valid), 0);
        check("arst busy", int'(busy), 0);
        check("arst sort_done", int'(sort_done), 0);
        check("arst in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst in_ready after", int'(in_ready), 1);
        run_vec(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sort_ctrl.md
Name: sort_ctrl

Overview:
- Sequencing controller that loads a block of DEPTH unsigned words, sorts them in place with one shared compare-and-swap step per cycle, then streams them out in ascending order.
- The compare step uses our N-bit magnitude comparator (equal / A-greater / B-greater) as its only arithmetic resource.
- Sits between a valid/ready producer and a valid/ready consumer.
- Intended for small sort and rank jobs in the ch2 datapath examples.

Parameters:
- WIDTH, 4, data word width in bits; passed to the comparator's N.
- DEPTH, 8, words per block; legal range 2..64; index width is $clog2(DEPTH).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort; returns the block to LOAD.
- in_valid  input  1  producer has a word.
- in_data  input  WIDTH  input word, unsigned.
- in_ready  output  1  block accepts a word this cycle.
- out_valid  output  1  out_data is valid.
- out_data  output  WIDTH  sorted word.
- out_ready  input  1  consumer accepts a word.
- busy  output  1  high while in SORT.
- sort_done  output  1  one-cycle pulse on entry to OUT.

Behaviour:
- Reset (asynchronous, active-high rst):
  - State goes to LOAD; write, read, compare and pass indices go to 0.
  - Storage array is cleared to 0.
  - Output reset values: in_ready=0, out_valid=0, out_data=0, busy=0, sort_done=0.
  - On the first clock after rst deasserts, in_ready=1.
- States: LOAD, SORT, OUT. All outputs are registered or decoded only from state and registers; there is no combinational in-to-out path.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, write in_data to mem[wr_idx] and increment wr_idx.
  - On acceptance of word DEPTH-1, go to SORT with j=0, pass=0, swapped=0.
- SORT (busy=1, in_ready=0, out_valid=0):
  - Each cycle compare A=mem[j] against B=mem[j+1].
  - If A_greater_than_B: swap the two words and set swapped.
  - If equal or B_greater_than_A: no swap. The sort is stable.
  - If j < DEPTH-2: increment j.
  - If j == DEPTH-2 (end of pass): let s = swapped OR the swap in this cycle.
    - If s==0, or pass == DEPTH-2: go to OUT.
    - Otherwise: j=0, pass+1, clear swapped.
- Sort latency:
  - One pass is DEPTH-1 cycles.
  - Best case (already sorted) is DEPTH-1 cycles.
  - Worst case (reverse order) is (DEPTH-1)^2 cycles; 49 cycles for DEPTH=8.
- OUT:
  - sort_done pulses in the first OUT cycle.
  - out_valid=1, out_data=mem[rd_idx].
  - On out_valid&&out_ready, increment rd_idx.
  - After the handshake of word DEPTH-1, go to LOAD with indices 0; in_ready=1 on the next cycle.
  - out_data is held stable while out_ready=0.
- flush:
  - In any state, flush returns to LOAD on the next edge and clears indices, pass and swapped. Storage is not cleared.
  - flush has priority over a simultaneous in_valid or out_ready handshake; that word is dropped or not consumed.
  - sort_done does not pulse after a flush.
  - rst mid-SORT or mid-OUT behaves as full reset; no partial output is resumed.
- Arithmetic and width rules:
  - Comparisons are unsigned at full WIDTH.
  - Index counters saturate at their terminal values as described above and never wrap mid-state.
- Back-pressure rules:
  - in_valid while not in LOAD is ignored.
  - out_ready while not in OUT is ignored.

Optional Feature:
- Macro: SORT_SWAP_CNT_EN.
- Defined:
  - Adds output port swap_count, width $clog2(DEPTH*(DEPTH-1)/2+1).
  - swap_count is cleared on entering SORT and on flush/rst.
  - It increments on every swap and holds its value through OUT until the next SORT.
  - For DEPTH=8 reverse input it reads 28 at sort_done.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then load 3,1,4,1,5,9,2,6 (WIDTH=4, DEPTH=8), out_ready=1:
  - sort_done fires once.
  - Output is 1,1,2,3,4,5,6,9.
  - out_valid is high for 8 consecutive cycles.
- Load already sorted 0..7:
  - busy is high exactly 7 cycles.
  - Output is 0..7.
  - swap_count=0 if enabled.
- Load 15,14,13,12,11,10,9,8:
  - busy is high exactly 49 cycles.
  - Output is 8..15.
  - swap_count=28 if enabled.
- Load all 7s; during OUT, toggle out_ready 1,0,0,1,...:
  - Eight 7s are emitted.
  - out_data and rd_idx are stable while out_ready=0.
  - in_ready stays 0 until the last handshake.
- Assert flush for 1 cycle at SORT cycle 10, with in_valid=1 in the same cycle:
  - Next cycle state is LOAD, in_ready=1, busy=0.
  - No sort_done pulse.
  - The word presented during flush is not stored.
- Assert rst asynchronously mid-OUT (between clock edges):
  - out_valid, busy and sort_done go 0 immediately.
  - After deassert, a fresh 8-word load sorts correctly.
